mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access pipeline stage of the core, between execute and writeback, directly upstream of the data-memory block. Accepts one operation at a time from execute and passes non-memory results through unchanged. Issues byte/half/word load and store requests to data memory over its `addr`/`r_enable`/`w_enable`/`w_size`/`w_data`/`r_data`/`ready` interface. Sign- or zero-extends load data and presents a single-cycle result to writeback.

## Interface
Parameters:
- `ADDR_W`, default 32: data address width; must equal the data-memory `addr` width (`ADDR_SIZE`+1).
- `XLEN`, default 32: data width; must equal the data-memory data width (`INSTR_SIZE`+1).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute presents an operation.
- `in_ready` out 1: stage can accept; high exactly when state is IDLE.
- `in_load`, `in_store` in 1 each: operation is a load or a store; both low means pass-through.
- `in_funct3` in 3: RV32 load/store funct3.
- `in_addr` in ADDR_W: effective address.
- `in_wdata` in XLEN: store data.
- `in_result` in XLEN: ALU result for pass-through operations.
- `in_rd` in 5: destination register.
- `in_reg_we` in 1: destination register write enable.
- `mem_addr` out ADDR_W, `mem_r_enable` out 1, `mem_w_enable` out 1, `mem_w_size` out 2, `mem_w_data` out XLEN: data-memory request. All are registered.
- `mem_r_data` in XLEN, `mem_ready` in 1: data-memory response.
- `out_valid` out 1: one-cycle retire pulse to writeback.
- `out_rd` out 5, `out_data` out XLEN, `out_reg_we` out 1: writeback payload, valid only while `out_valid` is high.

## Operation
- States: IDLE, STORE, LOAD_REQ, LOAD_WAIT. Reset enters IDLE.
- An operation is accepted on a rising edge where `in_valid` and `in_ready` are both high. All `in_*` fields are latched on that edge.
- Pass-through (`in_load`=`in_store`=0): state stays IDLE. Next cycle: `out_valid`=1, `out_data`=`in_result`, `out_rd`/`out_reg_we` copied from the inputs.
- Store: go to STORE.
  - In STORE: `mem_w_enable`=1, `mem_addr`=`in_addr`, `mem_w_data`=`in_wdata` (unshifted; data memory handles lane rotation), `mem_w_size`=`in_funct3[1:0]`.
  - Same cycle: `out_valid`=1 with `out_reg_we`=0.
  - Next state: IDLE.
- Load: go to LOAD_REQ.
  - In LOAD_REQ: `mem_r_enable`=1 for exactly one cycle. Next state: LOAD_WAIT.
  - In LOAD_WAIT: `mem_r_enable`=0 and `mem_addr` is held stable, because data memory selects read lanes from `addr[1:0]` combinationally.
  - On the edge where `mem_ready`=1, capture the extended `mem_r_data` into `out_data` and go to IDLE. `out_valid`=1 in the following cycle.
  - With no `mem_ready`, the stage stays in LOAD_WAIT indefinitely.
- Extension, using `mem_r_data` bits [7:0]/[15:0] (already aligned by data memory):
  - funct3 000: sign-extend byte.
  - 001: sign-extend half.
  - 010: full word.
  - 100: zero-extend byte.
  - 101: zero-extend half.
  - 011, 110, 111: treated as word.
- Store `mem_w_size`: funct3[1:0] 00 byte, 01 half, 10 word, 11 forced to 10.
- `in_load` and `in_store` both high: handled as a load; `in_store` is ignored.
- `mem_ready` arriving in any state other than LOAD_WAIT is ignored.
- Misaligned addresses are passed to data memory unchanged. No trap is raised.

## Timing
- Reset values:
  - State is IDLE and `in_ready`=1.
  - `mem_r_enable`, `mem_w_enable` and `out_valid` are 0.
  - `mem_addr`, `mem_w_data`, `mem_w_size`, `out_data`, `out_rd` and `out_reg_we` are all 0.
- Latency for an operation accepted at edge N:
  - Pass-through: `out_valid` in cycle N+1; back-to-back issue allowed every cycle.
  - Store: `mem_w_enable` and `out_valid` in cycle N+1; `in_ready` low in N+1; next accept at edge N+2.
  - Load, with a 1-cycle data memory: `mem_r_enable` in N+1, `mem_ready` in N+2, `out_valid` in N+3. `in_ready` low in N+1 and N+2; next accept at edge N+3.
- `out_valid` is never high for more than one cycle per operation. Writeback has no backpressure.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight operation is discarded without retiring. A stale `mem_ready` after reset is ignored.

## Structure
- In the shared `def_params` header:
  - funct3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - Memory size codes: `MEM_SIZE_BYTE` = 2'b00, `MEM_SIZE_HALF` = 2'b01, `MEM_SIZE_WORD` = 2'b10.
  - Stage state encoding.
- One combinational sub-module, `load_extend`: inputs funct3 and raw read data, output extended XLEN word. It is unit-tested separately.
- In simulation builds, a `$strobe` trace prints retired loads and stores, matching the data-memory trace format.

## Test plan
- Pass-through stream: three accepted ops with `in_result` 0x11, 0x22, 0x33 on consecutive edges -> `out_valid` high for three consecutive cycles with the same data in order; `in_ready` stays 1 throughout.
- SB to addr 0x05 with `in_wdata` 0xAABBCCDD -> one cycle of `mem_w_enable`=1 with `mem_w_size`=00, `mem_addr`=0x05, `mem_w_data`=0xAABBCCDD; `out_valid` pulse with `out_reg_we`=0.
- LB from 0x05 where data memory returns 0x000000F0 -> `out_data`=0xFFFFFFF0. Repeating as LBU -> 0x000000F0. LH returning 0x00008001 -> 0xFFFF8001.
- LW with `mem_ready` delayed 4 cycles -> `mem_addr` held constant, `mem_r_enable` high for exactly 1 cycle, `in_ready`=0 until the cycle after capture, exactly one `out_valid`.
- Reset asserted in LOAD_WAIT, then `mem_ready`=1 the cycle after release -> no `out_valid` pulse; outputs at reset values; stage accepts a new op immediately.
- `in_load`=`in_store`=1 with funct3 011 -> behaves as LW: `mem_r_enable` pulse, no `mem_w_enable`.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage: load/store funct3 codes,
// data-memory size codes and the stage state encoding.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STORE     = 2'd1,
        ST_LOAD_REQ  = 2'd2,
        ST_LOAD_WAIT = 2'd3
    } stage_state_e;

    // Reserved size encoding 11 is widened to a word access.
    function automatic logic [1:0] store_size(input logic [2:0] funct3);
        logic [1:0] size;
        case (funct3[1:0])
            2'b00:   size = MEM_SIZE_BYTE;
            2'b01:   size = MEM_SIZE_HALF;
            default: size = MEM_SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus; master is the pipeline stage, slave is
// the data memory.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) ();
    logic [ADDR_W-1:0] addr;
    logic              r_enable;
    logic              w_enable;
    logic [1:0]        w_size;
    logic [XLEN-1:0]   w_data;
    logic [XLEN-1:0]   r_data;
    logic              ready;

    modport master (
        output addr, r_enable, w_enable, w_size, w_data,
        input  r_data, ready
    );

    modport slave (
        input  addr, r_enable, w_enable, w_size, w_data,
        output r_data, ready
    );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Sign/zero extension of lane-aligned load data according to the load funct3.
module load_extend
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw_data,
    output logic [XLEN-1:0] ext_data
);

    // Unlisted encodings fall through to a full-word result.
    always_comb begin
        ext_data = raw_data;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){raw_data[7]}}, raw_data[7:0]};
            F3_LH:   ext_data = {{(XLEN-16){raw_data[15]}}, raw_data[15:0]};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, raw_data[7:0]};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, raw_data[15:0]};
            F3_LW:   ext_data = raw_data;
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, issues loads and
// stores to data memory and retires a single-cycle result to writeback.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_result,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_we,
    mem_access_stage_if.master mem_if,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_data,
    output logic              out_reg_we
);

    stage_state_e      state_q;
    logic [2:0]        funct3_q;
    logic              in_ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic              r_enable_q;
    logic              w_enable_q;
    logic [1:0]        w_size_q;
    logic [XLEN-1:0]   w_data_q;
    logic              out_valid_q;
    logic [4:0]        out_rd_q;
    logic [XLEN-1:0]   out_data_q;
    logic              out_reg_we_q;
    logic [XLEN-1:0]   ext_data_s;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3   (funct3_q),
        .raw_data (mem_if.r_data),
        .ext_data (ext_data_s)
    );

    // Stage FSM; every output is a register. addr_q is left untouched in
    // LOAD_WAIT so data memory keeps selecting the same read lanes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            funct3_q     <= 3'b000;
            in_ready_q   <= 1'b1;
            addr_q       <= {ADDR_W{1'b0}};
            r_enable_q   <= 1'b0;
            w_enable_q   <= 1'b0;
            w_size_q     <= 2'b00;
            w_data_q     <= {XLEN{1'b0}};
            out_valid_q  <= 1'b0;
            out_rd_q     <= 5'd0;
            out_data_q   <= {XLEN{1'b0}};
            out_reg_we_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            r_enable_q  <= 1'b0;
            w_enable_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        funct3_q <= in_funct3;
                        out_rd_q <= in_rd;
                        if (in_load) begin
                            state_q      <= ST_LOAD_REQ;
                            in_ready_q   <= 1'b0;
                            r_enable_q   <= 1'b1;
                            addr_q       <= in_addr;
                            out_reg_we_q <= in_reg_we;
                        end else if (in_store) begin
                            state_q      <= ST_STORE;
                            in_ready_q   <= 1'b0;
                            w_enable_q   <= 1'b1;
                            addr_q       <= in_addr;
                            w_data_q     <= in_wdata;
                            w_size_q     <= store_size(in_funct3);
                            out_valid_q  <= 1'b1;
                            out_reg_we_q <= 1'b0;
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_data_q   <= in_result;
                            out_reg_we_q <= in_reg_we;
                        end
                    end
                end
                ST_STORE: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
                ST_LOAD_REQ: begin
                    state_q <= ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (mem_if.ready) begin
                        out_data_q  <= ext_data_s;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_q;
    assign mem_if.addr     = addr_q;
    assign mem_if.r_enable = r_enable_q;
    assign mem_if.w_enable = w_enable_q;
    assign mem_if.w_size   = w_size_q;
    assign mem_if.w_data   = w_data_q;
    assign out_valid       = out_valid_q;
    assign out_rd          = out_rd_q;
    assign out_data        = out_data_q;
    assign out_reg_we      = out_reg_we_q;

endmodule
